// File: rtl/seq_bus_cycle.sv
// Bus cycle generator: owns the T1..T4 counter and turns the sequencer's
// per-M-cycle memory request into registered nmreq/nrd/nwr/doe strobes.
module seq_bus_cycle #(
  parameter int unsigned           AW       = 16,
  parameter int unsigned           DW       = 8,
  parameter logic [AW-1:0]         RST_ADDR = '0
) (
  input  logic          clk,
  input  logic          nres,
  input  logic          hold,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic [1:0]    tstate,
  output logic          mboundary,
  output logic          busy,
  output logic          nmreq,
  output logic          nrd,
  output logic          nwr,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] dout,
  output logic          doe,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] rdata,
  output logic          rvalid
);

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_READ  = 2'd1,
    BUS_WRITE = 2'd2
  } bus_e;

  localparam logic [1:0] T1 = 2'd0;
  localparam logic [1:0] T2 = 2'd1;
  localparam logic [1:0] T3 = 2'd2;
  localparam logic [1:0] T4 = 2'd3;

  bus_e          state_q, state_d;
  logic [1:0]    tstate_q, tstate_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          rvalid_q, rvalid_d;
  logic          busy_q, busy_d;
  logic          nmreq_q, nmreq_d;
  logic          nrd_q, nrd_d;
  logic          nwr_q, nwr_d;
  logic          doe_q, doe_d;

  always_comb begin
    state_d  = state_q;
    tstate_d = tstate_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    rdata_d  = rdata_q;
    ack_d    = ack_q;
    rvalid_d = rvalid_q;
    busy_d   = busy_q;
    nmreq_d  = nmreq_q;
    nrd_d    = nrd_q;
    nwr_d    = nwr_q;
    doe_d    = doe_q;

    if (!hold) begin
      tstate_d = tstate_q + 2'd1;

      if (tstate_q == T4) begin
        if (req) begin
          state_d = we ? BUS_WRITE : BUS_READ;
          addr_d  = addr_in;
          dout_d  = wdata;
        end else begin
          state_d = BUS_IDLE;
        end
      end

      if (state_q == BUS_READ && tstate_q == T3)
        rdata_d = din;

      // Strobes are decoded from the state being entered so every one of
      // them is a plain flop output changing on the edge into its T-state.
      busy_d   = (state_d != BUS_IDLE);
      ack_d    = (state_d != BUS_IDLE) && (tstate_d == T1);
      nmreq_d  = !((state_d != BUS_IDLE) && (tstate_d != T4));
      nrd_d    = !((state_d == BUS_READ) && (tstate_d != T4));
      nwr_d    = !((state_d == BUS_WRITE) && (tstate_d == T2 || tstate_d == T3));
      doe_d    = (state_d == BUS_WRITE) && (tstate_d != T1);
      rvalid_d = (state_d == BUS_READ) && (tstate_d == T4);
    end
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q  <= BUS_IDLE;
      tstate_q <= T1;
      addr_q   <= RST_ADDR;
      dout_q   <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      nmreq_q  <= 1'b1;
      nrd_q    <= 1'b1;
      nwr_q    <= 1'b1;
      doe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tstate_q <= tstate_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      nmreq_q  <= nmreq_d;
      nrd_q    <= nrd_d;
      nwr_q    <= nwr_d;
      doe_q    <= doe_d;
    end
  end

  // Pulses stay latched through a hold and are masked until it releases,
  // so each is seen exactly once.
  assign ack       = ack_q & ~hold;
  assign rvalid    = rvalid_q & ~hold;
  assign mboundary = (tstate_q == T4) & ~hold;

  assign tstate = tstate_q;
  assign busy   = busy_q;
  assign nmreq  = nmreq_q;
  assign nrd    = nrd_q;
  assign nwr    = nwr_q;
  assign addr   = addr_q;
  assign dout   = dout_q;
  assign doe    = doe_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_seq_bus_cycle.sv
// Randomized plus directed bench for seq_bus_cycle against a per-M-cycle
// behavioural model of the bus timing table.
module tb_seq_bus_cycle;

  logic        clk = 1'b0;
  logic        nres, hold, req, we;
  logic [15:0] addr_in, addr;
  logic [7:0]  wdata, dout, din, rdata;
  logic        ack, mboundary, busy, nmreq, nrd, nwr, doe, rvalid;
  logic [1:0]  tstate;

  seq_bus_cycle #(.AW(16), .DW(8), .RST_ADDR(16'h0000)) dut (
    .clk(clk), .nres(nres), .hold(hold), .req(req), .we(we),
    .addr_in(addr_in), .wdata(wdata), .ack(ack), .tstate(tstate),
    .mboundary(mboundary), .busy(busy), .nmreq(nmreq), .nrd(nrd),
    .nwr(nwr), .addr(addr), .dout(dout), .doe(doe), .din(din),
    .rdata(rdata), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  // Model: T-state index, whether the current M-cycle carries a transfer,
  // and the values latched for it.
  int          m_t;
  bit          m_act, m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_dout, m_rdata;

  int n_vec = 0, n_err = 0, cyc = 0;
  int ack_cnt = 0, rv_cnt = 0, last_ack = 0, last_rv = 0;
  int snap;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_t = 0; m_act = 0; m_we = 0;
    m_addr = 16'h0000; m_dout = 8'h00; m_rdata = 8'h00;
  endfunction

  function automatic void model_step();
    if (hold) return;
    if (m_act && !m_we && m_t == 2) m_rdata = din;
    if (m_t == 3) begin
      m_act = req;
      if (req) begin
        m_we = we; m_addr = addr_in; m_dout = wdata;
      end
    end
    m_t = (m_t + 1) % 4;
  endfunction

  task automatic check_all();
    bit rd, wr;
    rd = m_act && !m_we;
    wr = m_act && m_we;
    check_val("tstate",    32'(tstate),    32'(m_t));
    check_val("busy",      32'(busy),      32'(m_act));
    check_val("nmreq",     32'(nmreq),     32'(!(m_act && m_t < 3)));
    check_val("nrd",       32'(nrd),       32'(!(rd && m_t < 3)));
    check_val("nwr",       32'(nwr),       32'(!(wr && (m_t == 1 || m_t == 2))));
    check_val("doe",       32'(doe),       32'(wr && m_t > 0));
    check_val("ack",       32'(ack),       32'(m_act && m_t == 0 && !hold));
    check_val("rvalid",    32'(rvalid),    32'(rd && m_t == 3 && !hold));
    check_val("mboundary", 32'(mboundary), 32'(m_t == 3 && !hold));
    check_val("addr",      32'(addr),      32'(m_addr));
    check_val("dout",      32'(dout),      32'(m_dout));
    check_val("rdata",     32'(rdata),     32'(m_rdata));
    if (ack)    begin ack_cnt++; last_ack = cyc; end
    if (rvalid) begin rv_cnt++;  last_rv  = cyc; end
  endtask

  // Called at a falling edge: drive inputs, clock once, check at next fall.
  task automatic step(input logic h, input logic r, input logic w,
                      input logic [15:0] a, input logic [7:0] wd, input logic [7:0] di);
    hold = h; req = r; we = w; addr_in = a; wdata = wd; din = di;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic idle_to_t4();
    while (m_t != 3) step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
  endtask

  initial begin
    nres = 1'b0; hold = 1'b0; req = 1'b0; we = 1'b0;
    addr_in = '0; wdata = '0; din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    nres = 1'b1;

    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);

    // Plain read
    idle_to_t4();
    step(1'b0, 1'b1, 1'b0, 16'hC123, 8'h00, 8'h5A);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 8'h00, 8'h5A);
    check_val("rd_rdata", 32'(rdata), 32'h5A);
    check_val("rd_latency", 32'(last_rv - last_ack), 32'd3);

    // Plain write
    idle_to_t4();
    step(1'b0, 1'b1, 1'b1, 16'hFF80, 8'h3C, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 8'h00, 8'h00);
    check_val("wr_dout", 32'(dout), 32'h3C);

    // Back-to-back read then write with req held
    idle_to_t4();
    step(1'b0, 1'b1, 1'b0, 16'h0100, 8'h00, 8'h11);
    snap = last_ack;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 16'h0101, 8'h77, 8'h11);
    check_val("b2b_gap", 32'(last_ack - snap), 32'd4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 8'h00, 8'h00);

    // Read with a 3-clock hold in T2
    idle_to_t4();
    snap = rv_cnt;
    step(1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, 8'hA5);
    step(1'b0, 1'b0, 1'b0, 16'h0, 8'h00, 8'hA5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 8'h00, 8'hA5);
    step(1'b0, 1'b0, 1'b0, 16'h0, 8'h00, 8'hA5);
    step(1'b0, 1'b0, 1'b0, 16'h0, 8'h00, 8'hA5);
    check_val("hold_latency", 32'(last_rv - last_ack), 32'd6);
    check_val("hold_rv_once", 32'(rv_cnt - snap), 32'd1);

    // Asynchronous reset during T2 of a write
    idle_to_t4();
    step(1'b0, 1'b1, 1'b1, 16'h4242, 8'hC3, 8'h00);
    step(1'b0, 1'b1, 1'b1, 16'h4242, 8'hC3, 8'h00);
    #2 nres = 1'b0;
    #1;
    check_val("rst_nwr",   32'(nwr),   32'd1);
    check_val("rst_nmreq", 32'(nmreq), 32'd1);
    check_val("rst_doe",   32'(doe),   32'd0);
    model_reset();
    check_all();
    @(negedge clk);
    nres = 1'b1;
    snap = ack_cnt;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'h4242, 8'hC3, 8'h00);
    check_val("rst_no_ack", 32'(ack_cnt - snap), 32'd0);
    step(1'b0, 1'b1, 1'b1, 16'h4242, 8'hC3, 8'h00);
    check_val("rst_reaccept", 32'(ack_cnt - snap), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 5) == 0, 1'($urandom), 1'($urandom),
           16'($urandom), 8'($urandom), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
